// File: rtl/mgpio_irq_bank_if.sv
// ============================================================================
//  Module   : mgpio_irq_bank_if
//  Brief    : Register-bus bundle for the GPIO input/interrupt bank
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mgpio_irq_bank_if;
  logic       rise_en;
  logic [7:0] rise_in;
  logic       fall_en;
  logic [7:0] fall_in;
  logic       clr_en;
  logic [7:0] clr_in;
  logic [7:0] rise_out;
  logic [7:0] fall_out;
  logic [7:0] status_out;

  modport master (
    output rise_en, rise_in, fall_en, fall_in, clr_en, clr_in,
    input  rise_out, fall_out, status_out
  );

  modport slave (
    input  rise_en, rise_in, fall_en, fall_in, clr_en, clr_in,
    output rise_out, fall_out, status_out
  );
endinterface

`default_nettype wire

// File: rtl/mgpio_irq_bank.sv
// ============================================================================
//  Module   : mgpio_irq_bank
//  Brief    : Pad synchroniser, debouncer and edge-interrupt status for 8 pins
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mgpio_irq_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [7:0]            gpio_in,
  input  wire logic [7:0]            dir,
  input  wire logic [DEBOUNCE_W-1:0] db_cycles,
  mgpio_irq_bank_if.slave            bus,
  output logic [7:0]                 level_out,
  output logic                       irq
);

  logic [7:0] lvl;
  logic [7:0] rise_evt;
  logic [7:0] fall_evt;
  logic [7:0] rise_q;
  logic [7:0] fall_q;
  logic [7:0] status_q;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;

  for (genvar i = 0; i < 8; i++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   lvl_q;
    logic                   s;
    logic                   flip;

    assign s    = sync_q[SYNC_STAGES-1];
    // >= keeps a lowered threshold from stranding a counter above it
    assign flip = (s != lvl_q) && (cnt >= db_cycles);

    assign rise_evt[i] = flip &  s;
    assign fall_evt[i] = flip & ~s;
    assign lvl[i]      = lvl_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        cnt    <= '0;
        lvl_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in[i]};
        if (s == lvl_q) begin
          cnt <= '0;
        end else if (flip) begin
          lvl_q <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Output pins never raise events; set has priority over a same-cycle clear
  assign set_vec = ~dir & ((rise_evt & rise_q) | (fall_evt & fall_q));
  assign clr_vec = bus.clr_en ? bus.clr_in : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q   <= 8'h00;
      fall_q   <= 8'h00;
      status_q <= 8'h00;
    end else begin
      if (bus.rise_en) rise_q <= bus.rise_in;
      if (bus.fall_en) fall_q <= bus.fall_in;
      status_q <= (status_q & ~clr_vec) | set_vec;
    end
  end

  assign level_out      = lvl;
  assign bus.rise_out   = rise_q;
  assign bus.fall_out   = fall_q;
  assign bus.status_out = status_q;
  assign irq            = |status_q;

endmodule

`default_nettype wire

// File: tb/tb_mgpio_irq_bank.sv
// ============================================================================
//  Module   : tb_mgpio_irq_bank
//  Brief    : Directed and randomized checks of mgpio_irq_bank against a model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mgpio_irq_bank;
  localparam int SS = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    gpio_in = 8'h00;
  logic [7:0]    dir = 8'h00;
  logic [DW-1:0] db_cycles = '0;
  logic [7:0]    level_out;
  logic          irq;

  int total = 0;
  int bad   = 0;

  mgpio_irq_bank_if bus ();

  mgpio_irq_bank #(.SYNC_STAGES(SS), .DEBOUNCE_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .dir       (dir),
    .db_cycles (db_cycles),
    .bus       (bus),
    .level_out (level_out),
    .irq       (irq)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the synchronised pad has disagreed
  // with it for db_cycles+1 consecutive samples.
  logic [7:0] m_pipe [SS];
  logic [7:0] m_lvl  = 8'h00;
  logic [7:0] m_rise = 8'h00;
  logic [7:0] m_fall = 8'h00;
  logic [7:0] m_sts  = 8'h00;
  int         m_run [8];

  task automatic m_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = 8'h00;
    for (int k = 0; k < 8; k++) m_run[k] = 0;
    m_lvl = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_sts = 8'h00;
  endtask

  task automatic m_step();
    logic [7:0] s, ev_r, ev_f, clr;
    s = m_pipe[SS-1]; ev_r = 8'h00; ev_f = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (s[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] >= int'(db_cycles) + 1) begin
          ev_r[k] = s[k]; ev_f[k] = ~s[k]; m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_lvl = m_lvl ^ (ev_r | ev_f);
    clr   = bus.clr_en ? bus.clr_in : 8'h00;
    m_sts = (m_sts & ~clr) | (~dir & ((ev_r & m_rise) | (ev_f & m_fall)));
    if (bus.rise_en) m_rise = bus.rise_in;
    if (bus.fall_en) m_fall = bus.fall_in;
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = gpio_in;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  always @(posedge clk) begin
    #2;
    check("m_lvl",  {24'h0, level_out},      {24'h0, m_lvl});
    check("m_sts",  {24'h0, bus.status_out}, {24'h0, m_sts});
    check("m_irq",  {31'h0, irq},            {31'h0, |m_sts});
    check("m_rise", {24'h0, bus.rise_out},   {24'h0, m_rise});
    check("m_fall", {24'h0, bus.fall_out},   {24'h0, m_fall});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_rise(input logic [7:0] v);
    bus.rise_en = 1'b1; bus.rise_in = v; step(1); bus.rise_en = 1'b0;
  endtask

  task automatic wr_fall(input logic [7:0] v);
    bus.fall_en = 1'b1; bus.fall_in = v; step(1); bus.fall_en = 1'b0;
  endtask

  task automatic clear(input logic [7:0] v);
    bus.clr_en = 1'b1; bus.clr_in = v; step(1); bus.clr_en = 1'b0;
  endtask

  initial begin
    bus.rise_en = 1'b0; bus.rise_in = 8'h00;
    bus.fall_en = 1'b0; bus.fall_in = 8'h00;
    bus.clr_en  = 1'b0; bus.clr_in  = 8'h00;

    step(3);
    check("rst_lvl",  {24'h0, level_out},      32'h00);
    check("rst_sts",  {24'h0, bus.status_out}, 32'h00);
    check("rst_irq",  {31'h0, irq},            32'h0);
    check("rst_rise", {24'h0, bus.rise_out},   32'h00);
    check("rst_fall", {24'h0, bus.fall_out},   32'h00);
    rst = 1'b1;
    step(1);

    // Rising edge on pin 0, zero debounce
    wr_rise(8'h01);
    check("rise_rb", {24'h0, bus.rise_out}, 32'h01);
    gpio_in[0] = 1'b1;
    step(2);
    check("lat_e2", {31'h0, level_out[0]}, 32'h0);
    step(1);
    check("lat_e3", {31'h0, level_out[0]}, 32'h1);
    check("sts_e3", {24'h0, bus.status_out}, 32'h01);
    check("irq_e3", {31'h0, irq}, 32'h1);
    gpio_in[0] = 1'b0;
    step(6);
    check("fall_ign", {24'h0, bus.status_out}, 32'h01);
    clear(8'h01);
    check("clr0", {24'h0, bus.status_out}, 32'h00);

    // Debounce glitch filtering on pin 7
    db_cycles = 4'd4;
    wr_fall(8'h80);
    gpio_in[7] = 1'b1;
    step(12);
    check("p7_hi", {31'h0, level_out[7]}, 32'h1);
    check("p7_hi_sts", {24'h0, bus.status_out}, 32'h00);
    gpio_in[7] = 1'b0; step(3); gpio_in[7] = 1'b1;
    step(12);
    check("glitch_lvl", {31'h0, level_out[7]}, 32'h1);
    check("glitch_sts", {24'h0, bus.status_out}, 32'h00);
    gpio_in[7] = 1'b0;
    step(6);
    check("db_e6", {31'h0, level_out[7]}, 32'h1);
    step(1);
    check("db_e7", {31'h0, level_out[7]}, 32'h0);
    check("db_sts7", {24'h0, bus.status_out}, 32'h80);
    step(1);
    gpio_in[7] = 1'b1;

    // Selective write-1-to-clear
    gpio_in[0] = 1'b1;
    step(10);
    check("sts81", {24'h0, bus.status_out}, 32'h81);
    clear(8'h01);
    check("clr01_sts", {24'h0, bus.status_out}, 32'h80);
    check("clr01_irq", {31'h0, irq}, 32'h1);
    clear(8'h80);
    check("clr80_sts", {24'h0, bus.status_out}, 32'h00);
    check("clr80_irq", {31'h0, irq}, 32'h0);

    // Set beats a same-cycle clear
    db_cycles = 4'd0;
    wr_rise(8'h04);
    gpio_in[2] = 1'b1; step(3);
    check("b2_set", {24'h0, bus.status_out}, 32'h04);
    gpio_in[2] = 1'b0; step(4);
    gpio_in[2] = 1'b1; step(2);
    bus.clr_en = 1'b1; bus.clr_in = 8'h04;
    step(1);
    bus.clr_en = 1'b0;
    check("setwins", {24'h0, bus.status_out}, 32'h04);
    check("setwins_lvl", {31'h0, level_out[2]}, 32'h1);
    clear(8'h04);
    check("b2_clr", {24'h0, bus.status_out}, 32'h00);

    // Output pins: level tracks pads, no events
    dir = 8'hFF;
    wr_rise(8'hFF);
    wr_fall(8'hFF);
    for (int k = 0; k < 6; k++) begin
      gpio_in = 8'($urandom);
      step(4);
      check("out_lvl", {24'h0, level_out}, {24'h0, gpio_in});
      check("out_sts", {24'h0, bus.status_out}, 32'h00);
      check("out_irq", {31'h0, irq}, 32'h0);
    end

    // Async reset in the middle of a debounce
    gpio_in = 8'h00; step(4);
    dir = 8'h00; step(1);
    check("pre3c", {24'h0, bus.status_out}, 32'h00);
    gpio_in = 8'h3C; step(3);
    check("sts3c", {24'h0, bus.status_out}, 32'h3C);
    db_cycles = 4'd6;
    gpio_in[0] = 1'b1;
    step(4);
    #2 rst = 1'b0;
    #1;
    check("arst_lvl",  {24'h0, level_out},      32'h00);
    check("arst_sts",  {24'h0, bus.status_out}, 32'h00);
    check("arst_irq",  {31'h0, irq},            32'h0);
    check("arst_rise", {24'h0, bus.rise_out},   32'h00);
    check("arst_fall", {24'h0, bus.fall_out},   32'h00);
    step(2);
    rst = 1'b1;
    step(8);
    check("rel_e8", {24'h0, level_out}, 32'h00);
    step(1);
    check("rel_e9", {24'h0, level_out}, 32'h3D);
    check("rel_sts", {24'h0, bus.status_out}, 32'h00);

    // Randomized traffic against the model
    db_cycles = 4'd1;
    wr_rise(8'($urandom));
    wr_fall(8'($urandom));
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.rise_en = ($urandom_range(0, 19) == 0); bus.rise_in = 8'($urandom);
      bus.fall_en = ($urandom_range(0, 19) == 0); bus.fall_in = 8'($urandom);
      bus.clr_en  = ($urandom_range(0, 9) == 0);  bus.clr_in  = 8'($urandom);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) gpio_in[b] = ~gpio_in[b];
      if ($urandom_range(0, 59) == 0) dir = 8'($urandom);
      if ($urandom_range(0, 149) == 0) db_cycles = DW'($urandom_range(0, 3));
      if (c == 700) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    bus.rise_en = 1'b0; bus.fall_en = 1'b0; bus.clr_en = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
